display_scanner: RTL
====================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clock cycles per digit slot (legal range 1..65535).
REQ-002 Parameter: W, default 16, width of the value input.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 value  input  W  unsigned binary magnitude from the counter stage, nominal range 0..9999.
REQ-006 sign  input  1  counter sign; 1 = positive, 0 = negative.
REQ-007 seg  output  7  registered, active-low segment drive, bit order {g,f,e,d,c,b,a}.
REQ-008 an  output  5  registered, active-low one-hot digit enable; an[0] = ones, an[3] = thousands, an[4] = sign digit.
REQ-009 busy  output  1  high while a BCD conversion is in progress.
REQ-010 ovf  output  1  high while the displayed frame came from value > 9999.

Function
REQ-011 The converter FSM SHALL have exactly three states: IDLE, CONV and LOAD.
REQ-012 IDLE: on each clock, sample value and sign, clear the BCD accumulator and go to CONV; no other IDLE behaviour.
REQ-013 Sampling: a sampled value > 9999 SHALL be replaced by 9999, and an overflow flag captured alongside it.
REQ-014 CONV: SHALL run exactly 16 cycles of shift-and-add-3 (double-dabble), one bit per cycle, MSB first, then go to LOAD.
REQ-015 LOAD: SHALL write the four BCD digits, the sign and the overflow flag into the display registers in one cycle, then go to IDLE.
REQ-016 Conversion period SHALL be 18 cycles; display registers SHALL change only in LOAD, so a frame is never torn.
REQ-017 busy SHALL be 1 in CONV and LOAD, and 0 in IDLE.
REQ-018 Input changes during CONV/LOAD SHALL be ignored until the next IDLE sample.
REQ-019 Prescaler: SHALL count 0..SCAN_DIV-1 and wrap to 0; at terminal count the digit index SHALL advance 0,1,2,3,4,0...
REQ-020 SCAN_DIV=1: the digit index SHALL advance every cycle.
REQ-021 an SHALL equal the active-low one-hot of the digit index, registered one cycle after the index update, together with the matching seg.
REQ-022 Digit slots 0..3: seg SHALL carry the standard decimal pattern for that digit (0 = 7'h40, 1 = 7'h79, ..., 9 = 7'h10).
REQ-023 Sign slot (4): seg SHALL be 7'h3F (minus) when the latched sign = 0 and the latched magnitude != 0, else 7'h7F (blank); negative zero SHALL display as blank.
REQ-024 ovf SHALL follow the latched overflow flag and update only in LOAD.

Reset
REQ-025 While reset = 0: seg = 7'h7F, an = 5'h1F, busy = 0, ovf = 0, FSM = IDLE, prescaler = 0, digit index = 0, all display registers = 0, latched sign = 1.
REQ-026 Reset asserted mid-CONV SHALL abort the conversion immediately; no partial result reaches the display registers.
REQ-027 On the first clock after reset release, the block SHALL sample the inputs (IDLE) and start scanning from slot 0.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN, when defined: zero digits above the most significant non-zero digit SHALL show 7'h7F; digit 0 SHALL always be shown, so value 0 displays a single "0".
REQ-029 Macro LEADING_ZERO_BLANK_EN, when not defined: all four digits SHALL always be shown, including leading zeros (e.g. 0042).

Verification (SCAN_DIV=4)
REQ-030 Scenario: hold reset = 0 for 5 cycles -> seg = 7'h7F, an = 5'h1F, busy = 0, ovf = 0; release -> busy = 1 on the next cycle, first LOAD after 18 cycles.
REQ-031 Scenario: value = 1234, sign = 1 -> slots 3..0 show 1, 2, 3, 4 (7'h79, 7'h24, 7'h30, 7'h19); slot 4 = 7'h7F; each an low for 4 cycles.
REQ-032 Scenario: value = 7, sign = 0 -> slot 4 = 7'h3F, slot 0 = 7'h78; slots 3..1 = 7'h7F with LEADING_ZERO_BLANK_EN defined, 7'h40 without.
REQ-033 Scenario: value = 12000 -> digits display 9999 and ovf = 1; then value = 5 -> ovf = 0 after the next LOAD.
REQ-034 Scenario: value changes 1111 -> 2222 in the 8th CONV cycle -> the LOAD of that conversion shows 1111; 2222 appears after the following conversion.
REQ-035 Scenario: value = 0, sign = 0 -> slot 4 blank (7'h7F), slot 0 = 7'h40; reset pulse mid-CONV -> outputs return to reset values with no partial frame.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: double-dabble BCD converter feeding a 5-slot multiplexed 7-segment scanner.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant non-zero digit.
module display_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] value,
    input  logic         sign,
    output logic [6:0]   seg,
    output logic [4:0]   an,
    output logic         busy,
    output logic         ovf
);
    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] bin_q, bin_d, bcd_q, bcd_d, bcd_adj;
    logic        sgn_q, sgn_d, ovf_s_q, ovf_s_d;
    logic [15:0] disp_q, disp_d;
    logic        disp_sgn_q, disp_sgn_d, ovf_q, ovf_d;
    logic [15:0] pre_q, pre_d;
    logic [2:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [4:0]  an_q, an_d;
    logic        busy_q, busy_d;
    logic [3:0]  digit;
    logic        over, pre_last, blank;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0: dec7 = 7'h40;
            4'd1: dec7 = 7'h79;
            4'd2: dec7 = 7'h24;
            4'd3: dec7 = 7'h30;
            4'd4: dec7 = 7'h19;
            4'd5: dec7 = 7'h12;
            4'd6: dec7 = 7'h02;
            4'd7: dec7 = 7'h78;
            4'd8: dec7 = 7'h00;
            4'd9: dec7 = 7'h10;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        over = 32'(value) > 32'd9999;
        for (int i = 0; i < 4; i++)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        state_d    = state_q;
        bit_d      = bit_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        sgn_d      = sgn_q;
        ovf_s_d    = ovf_s_q;
        disp_d     = disp_q;
        disp_sgn_d = disp_sgn_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                bin_d   = over ? 16'd9999 : 16'(value);
                sgn_d   = sign;
                ovf_s_d = over;
                bcd_d   = '0;
                bit_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                // adjust-then-shift; the top bit of the shifted pair falls off
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                bit_d          = bit_q + 4'd1;
                state_d        = bit_q == 4'd15 ? LOAD : CONV;
            end
            LOAD: begin
                disp_d     = bcd_q;
                disp_sgn_d = sgn_q;
                ovf_d      = ovf_s_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_comb begin
        pre_last = pre_q == 16'(SCAN_DIV - 1);
        pre_d    = pre_last ? '0 : pre_q + 16'd1;
        idx_d    = pre_last ? (idx_q == 3'd4 ? '0 : idx_q + 3'd1) : idx_q;
        digit    = disp_q[4*idx_q[1:0] +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_q == 3'd3 && disp_q[15:12] == '0) ||
                (idx_q == 3'd2 && disp_q[15:8]  == '0) ||
                (idx_q == 3'd1 && disp_q[15:4]  == '0);
`else
        blank = 1'b0;
`endif
        // negative zero shows a blank sign slot
        seg_d = idx_q == 3'd4 ? ((!disp_sgn_q && disp_q != '0) ? 7'h3F : 7'h7F)
                              : (blank ? 7'h7F : dec7(digit));
        an_d  = ~(5'b1 << idx_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            sgn_q      <= 1'b1;
            ovf_s_q    <= 1'b0;
            disp_q     <= '0;
            disp_sgn_q <= 1'b1;
            ovf_q      <= 1'b0;
            pre_q      <= '0;
            idx_q      <= '0;
            seg_q      <= 7'h7F;
            an_q       <= 5'h1F;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            sgn_q      <= sgn_d;
            ovf_s_q    <= ovf_s_d;
            disp_q     <= disp_d;
            disp_sgn_q <= disp_sgn_d;
            ovf_q      <= ovf_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            busy_q     <= busy_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;
endmodule
